// File: rtl/mem_stage_pkg.sv
// Shared types for the multi-cycle memory stage.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DUMP,
    HALT
  } state_e;

endpackage

// File: rtl/dmem_sp.sv
// Single-port synchronous data RAM; a write also drives the new word onto rdata.
module dmem_sp
  import mem_stage_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 256,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
        rdata     <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/mem_stage_mc.sv
// Multi-cycle MEM stage: MEM/WB register, latency-configurable data memory access,
// misalignment flagging and a post-halt memory dump.
module mem_stage_mc
  import mem_stage_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int DEPTH   = 256,
  parameter int MEM_LAT = 1,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] ALU,
  input  logic [DATA_W-1:0] writeData,
  input  logic [DATA_W-1:0] PC,
  input  logic              readEn,
  input  logic              MemWrt,
  input  logic              halt,
  output logic              busy,
  output logic              out_valid,
  output logic [DATA_W-1:0] ALU_ff,
  output logic [DATA_W-1:0] PC_Next,
  output logic [DATA_W-1:0] readData,
  output logic              misalign,
  output logic              dump_valid,
  output logic [AW-1:0]     dump_addr,
  output logic [DATA_W-1:0] dump_data,
  output logic              halted
);

  localparam int              LAT_W     = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LAT - 1);
  localparam logic [AW-1:0]   LAST_WORD = AW'(DEPTH - 1);
  localparam bit              LONG      = (MEM_LAT > 1);

  state_e            state_reg, state_next;
  logic [LAT_W-1:0]  lat_cnt_reg;
  logic [AW-1:0]     dump_cnt_reg;
  logic [DATA_W-1:0] op_alu_reg, op_wdata_reg, op_pc_reg;
  logic              op_rd_reg, op_wr_reg;

  logic              out_valid_reg, misalign_reg, rd_sel_reg, dump_valid_reg, halted_reg;
  logic [DATA_W-1:0] alu_ff_reg, pc_next_reg, rd_hold_reg;
  logic [AW-1:0]     dump_addr_reg;

  logic              accept, in_mis, in_access, go_long, done_now, commit;
  logic              ram_en, ram_we;
  logic [AW-1:0]     ram_addr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;

  assign busy      = (state_reg != IDLE);
  assign accept    = in_valid & ~busy & ~halted_reg;
  assign in_mis    = (readEn | MemWrt) & ALU[0];
  assign in_access = (readEn | MemWrt) & ~ALU[0] & ~halt;
  assign go_long   = accept & in_access & LONG;
  assign done_now  = accept & ~go_long;
  assign commit    = (state_reg == ACCESS) && (lat_cnt_reg == LAT_W'(1));

  // Single RAM port shared by same-edge accesses, delayed commits and the dump walk.
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = ALU[AW:1];
    ram_wdata = writeData;
    if (state_reg == ACCESS) begin
      ram_addr  = op_alu_reg[AW:1];
      ram_wdata = op_wdata_reg;
      ram_en    = commit;
      ram_we    = commit & op_wr_reg;
    end else if (state_reg == DUMP) begin
      ram_addr = dump_cnt_reg;
      ram_en   = 1'b1;
    end else if (accept & in_access & ~LONG) begin
      ram_en = 1'b1;
      ram_we = MemWrt;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept & halt)  state_next = DUMP;
        else if (go_long)   state_next = ACCESS;
      end
      ACCESS:  if (commit) state_next = IDLE;
      DUMP:    if (dump_cnt_reg == LAST_WORD) state_next = HALT;
      HALT:    state_next = HALT;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      lat_cnt_reg  <= '0;
      dump_cnt_reg <= '0;
      op_alu_reg   <= '0;
      op_wdata_reg <= '0;
      op_pc_reg    <= '0;
      op_rd_reg    <= 1'b0;
      op_wr_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (go_long) begin
        lat_cnt_reg  <= LAT_LOAD;
        op_alu_reg   <= ALU;
        op_wdata_reg <= writeData;
        op_pc_reg    <= PC;
        op_rd_reg    <= readEn;
        op_wr_reg    <= MemWrt;
      end else if (state_reg == ACCESS) begin
        lat_cnt_reg <= lat_cnt_reg - 1'b1;
      end
      if (state_reg == DUMP && dump_cnt_reg != LAST_WORD)
        dump_cnt_reg <= dump_cnt_reg + 1'b1;
    end
  end

  // Load data lives in the RAM output register for the completing cycle, then is
  // copied into rd_hold_reg so readData keeps it while the RAM port is reused.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_reg  <= 1'b0;
      alu_ff_reg     <= '0;
      pc_next_reg    <= '0;
      misalign_reg   <= 1'b0;
      rd_sel_reg     <= 1'b0;
      rd_hold_reg    <= '0;
      dump_valid_reg <= 1'b0;
      dump_addr_reg  <= '0;
      halted_reg     <= 1'b0;
    end else begin
      if (done_now) begin
        out_valid_reg <= 1'b1;
        alu_ff_reg    <= ALU;
        pc_next_reg   <= PC;
        misalign_reg  <= in_mis;
        rd_sel_reg    <= in_access & readEn & ~MemWrt;
        rd_hold_reg   <= '0;
      end else if (commit) begin
        out_valid_reg <= 1'b1;
        alu_ff_reg    <= op_alu_reg;
        pc_next_reg   <= op_pc_reg;
        misalign_reg  <= 1'b0;
        rd_sel_reg    <= op_rd_reg & ~op_wr_reg;
        rd_hold_reg   <= '0;
      end else begin
        out_valid_reg <= 1'b0;
        rd_sel_reg    <= 1'b0;
        if (rd_sel_reg) rd_hold_reg <= ram_rdata;
      end
      dump_valid_reg <= (state_reg == DUMP);
      if (state_reg == DUMP) dump_addr_reg <= dump_cnt_reg;
      halted_reg <= halted_reg | (state_reg == HALT);
    end
  end

  dmem_sp #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_dmem (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  assign out_valid  = out_valid_reg;
  assign ALU_ff     = alu_ff_reg;
  assign PC_Next    = pc_next_reg;
  assign readData   = rd_sel_reg ? ram_rdata : rd_hold_reg;
  assign misalign   = misalign_reg;
  assign dump_valid = dump_valid_reg;
  assign dump_addr  = dump_addr_reg;
  assign dump_data  = dump_valid_reg ? ram_rdata : '0;
  assign halted     = halted_reg;

endmodule
